// File: rtl/alu_pkg.sv
// ============================================================================
// Module   : alu_pkg
// Purpose  : Opcode and state encodings plus default slice geometry for the
//            sequential ALU core.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_pkg;

  localparam int c_default_width = 4;
  localparam int c_default_n_alu = 4;

  typedef enum logic [2:0] {
    OP_ADD   = 3'd0,
    OP_SUB   = 3'd1,
    OP_MUL   = 3'd2,
    OP_AND   = 3'd3,
    OP_OR    = 3'd4,
    OP_XOR   = 3'd5,
    OP_CMP   = 3'd6,
    OP_PASSA = 3'd7
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MULT = 2'd1,
    ST_DONE = 2'd2
  } alu_state_e;

endpackage

`default_nettype wire

// File: rtl/alu_seq_mult.sv
// ============================================================================
// Module   : alu_seq_mult
// Purpose  : Iterative shift-add multiplier, one multiplier bit per cycle.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_seq_mult #(
  parameter int W = 16
) (
  input  logic           clk,
  input  logic           arst,
  input  logic           start,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic [2*W-1:0] product,
  output logic           last
);

  localparam int c_cnt_w = $clog2(W);

  logic [2*W-1:0]     r_mcand;
  logic [W-1:0]       r_mplier;
  logic [2*W-1:0]     r_acc;
  logic [c_cnt_w-1:0] r_cnt;
  logic               r_run;
  logic [2*W-1:0]     w_addend;

  // product is the accumulator after the current iteration, so the final
  // value is available at the very edge that completes iteration W.
  assign w_addend = r_mplier[0] ? r_mcand : '0;
  assign product  = r_acc + w_addend;
  assign last     = r_run && (r_cnt == c_cnt_w'(W - 1));

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_run    <= 1'b0;
    end else if (start) begin
      r_mcand  <= {{W{1'b0}}, a};
      r_mplier <= b;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_run    <= 1'b1;
    end else if (r_run) begin
      r_acc    <= product;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt + c_cnt_w'(1);
      if (last) begin
        r_run <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/alu_seq_core.sv
// ============================================================================
// Module   : alu_seq_core
// Purpose  : Sequential ALU responder: single-cycle ops plus an iterative
//            multiply, with registered results, flags and a done strobe.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_seq_core
  import alu_pkg::*;
#(
  parameter int WIDTH = c_default_width,
  parameter int N_ALU = c_default_n_alu
) (
  input  logic                     clk,
  input  logic                     arst,
  input  logic                     enable,
  input  logic [2:0]               select,
  input  logic [WIDTH*N_ALU-1:0]   a,
  input  logic [WIDTH*N_ALU-1:0]   b,
  output logic [8*WIDTH*N_ALU-1:0] out,
  output logic                     carry_out,
  output logic                     a_greater,
  output logic                     a_equal,
  output logic                     a_less,
  output logic                     busy,
  output logic                     done
);

  localparam int c_w  = WIDTH * N_ALU;
  localparam int c_ow = 8 * c_w;

  alu_state_e       r_state;
  alu_state_e       w_next;
  alu_op_e          w_op;
  logic             w_accept;
  logic             w_mul_start;
  logic             w_mul_last;
  logic [2*c_w-1:0] w_product;
  logic [c_w:0]     w_sum;
  logic [c_w-1:0]   w_result;
  logic             w_carry;

  logic [c_ow-1:0]  r_out;
  logic             r_carry;
  logic             r_gt;
  logic             r_eq;
  logic             r_lt;
  logic             r_busy;
  logic             r_done;

  assign w_op        = alu_op_e'(select);
  assign w_accept    = enable && (r_state != ST_MULT);
  assign w_mul_start = w_accept && (w_op == OP_MUL);
  assign w_sum       = {1'b0, a} + {1'b0, b};

  alu_seq_mult #(
    .W (c_w)
  ) u_mult (
    .clk     (clk),
    .arst    (arst),
    .start   (w_mul_start),
    .a       (a),
    .b       (b),
    .product (w_product),
    .last    (w_mul_last)
  );

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (w_accept) begin
          w_next = (w_op == OP_MUL) ? ST_MULT : ST_DONE;
        end else if (r_state == ST_DONE) begin
          w_next = ST_IDLE;
        end
      end
      ST_MULT: begin
        if (w_mul_last) begin
          w_next = ST_DONE;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_result = '0;
    w_carry  = 1'b0;
    case (w_op)
      OP_ADD: begin
        w_result = w_sum[c_w-1:0];
        w_carry  = w_sum[c_w];
      end
      OP_SUB: begin
        w_result = (a >= b) ? (a - b) : (b - a);
        w_carry  = (b > a);
      end
      OP_AND:   w_result = a & b;
      OP_OR:    w_result = a | b;
      OP_XOR:   w_result = a ^ b;
      OP_PASSA: w_result = a;
      default:  w_result = '0;
    endcase
  end

  // Outputs only move on an accepted single-cycle op or on multiply
  // completion; busy/done track the registered next state.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_out   <= '0;
      r_carry <= 1'b0;
      r_gt    <= 1'b0;
      r_eq    <= 1'b0;
      r_lt    <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_gt <= (a > b);
        r_eq <= (a == b);
        r_lt <= (a < b);
        if (w_op != OP_MUL) begin
          r_out   <= c_ow'(w_result);
          r_carry <= w_carry;
        end
      end
      if (w_mul_last) begin
        r_out   <= c_ow'(w_product);
        r_carry <= 1'b0;
      end
      r_busy <= (w_next == ST_MULT);
      r_done <= (w_next == ST_DONE);
    end
  end

  assign out       = r_out;
  assign carry_out = r_carry;
  assign a_greater = r_gt;
  assign a_equal   = r_eq;
  assign a_less    = r_lt;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule

`default_nettype wire

// File: tb/tb_alu_seq_core.sv
// ============================================================================
// Module   : tb_alu_seq_core
// Purpose  : Scoreboard bench for alu_seq_core with directed vectors.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_seq_core;

  localparam int c_w  = 16;
  localparam int c_ow = 128;

  typedef struct packed {
    logic [c_ow-1:0] out;
    logic            c;
    logic            gt;
    logic            eq;
    logic            lt;
  } exp_t;

  logic            clk = 1'b0;
  logic            arst;
  logic            enable;
  logic [2:0]      select;
  logic [c_w-1:0]  a;
  logic [c_w-1:0]  b;
  logic [c_ow-1:0] out;
  logic            carry_out;
  logic            a_greater;
  logic            a_equal;
  logic            a_less;
  logic            busy;
  logic            done;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   n_done   = 0;

  always #5 clk = ~clk;

  alu_seq_core u_dut (
    .clk       (clk),
    .arst      (arst),
    .enable    (enable),
    .select    (select),
    .a         (a),
    .b         (b),
    .out       (out),
    .carry_out (carry_out),
    .a_greater (a_greater),
    .a_equal   (a_equal),
    .a_less    (a_less),
    .busy      (busy),
    .done      (done)
  );

  // Monitor: every done cycle must match the oldest expected response.
  always @(negedge clk) begin
    exp_t e;
    if (!arst && done) begin
      n_done++;
      n_checks++;
      if (sb.size() == 0) begin
        n_errors++;
        $display("FAIL unexpected_done out=%h carry=%b", out, carry_out);
      end else begin
        e = sb.pop_front();
        if ({out, carry_out, a_greater, a_equal, a_less} !== e) begin
          n_errors++;
          $display("FAIL result got out=%h c=%b g/e/l=%b%b%b want out=%h c=%b g/e/l=%b%b%b",
                   out, carry_out, a_greater, a_equal, a_less,
                   e.out, e.c, e.gt, e.eq, e.lt);
        end
      end
    end
  end

  task automatic check(input string name, input logic [c_ow-1:0] got,
                       input logic [c_ow-1:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  task automatic issue(input logic [2:0] op, input logic [c_w-1:0] ta,
                       input logic [c_w-1:0] tb, input logic [c_ow-1:0] eo,
                       input logic ec, input logic egt, input logic eeq,
                       input logic elt, input bit push);
    exp_t e;
    enable = 1'b1;
    select = op;
    a      = ta;
    b      = tb;
    e      = '{out: eo, c: ec, gt: egt, eq: eeq, lt: elt};
    if (push) sb.push_back(e);
    @(posedge clk);
    #1;
    enable = 1'b0;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 100; i++) begin
      if (sb.size() == 0) break;
      @(negedge clk);
    end
    check(name, c_ow'(sb.size()), '0);
    sb.delete();
  endtask

  // Count busy cycles between the accept edge and the done cycle.
  task automatic measure_mul(input string name);
    int  cnt;
    bit  seen;
    cnt  = 0;
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done) begin
        seen = 1;
        break;
      end
      if (busy) cnt++;
    end
    check({name, "_busy_cycles"}, c_ow'(cnt), c_ow'(16));
    check({name, "_done_seen"}, c_ow'(seen), c_ow'(1));
  endtask

  initial begin
    int d0;
    arst   = 1'b1;
    enable = 1'b0;
    select = '0;
    a      = '0;
    b      = '0;
    repeat (3) @(negedge clk);
    check("reset_out", out, '0);
    check("reset_ctl", c_ow'({carry_out, a_greater, a_equal, a_less, busy, done}), '0);
    @(posedge clk);
    #1 arst = 1'b0;

    // ADD wrap with carry; done for exactly one cycle
    d0 = n_done;
    issue(3'd0, 16'hFFFF, 16'h0001, '0, 1'b1, 1'b1, 1'b0, 1'b0, 1);
    repeat (4) @(negedge clk);
    drain("add_wrap_drain");
    check("add_done_count", c_ow'(n_done - d0), c_ow'(1));

    // back-to-back SUBs
    d0 = n_done;
    issue(3'd1, 16'd3, 16'd10, c_ow'(7), 1'b1, 1'b0, 1'b0, 1'b1, 1);
    issue(3'd1, 16'd10, 16'd10, '0, 1'b0, 1'b0, 1'b1, 1'b0, 1);
    repeat (4) @(negedge clk);
    drain("sub_drain");
    check("sub_done_count", c_ow'(n_done - d0), c_ow'(2));

    // full-scale multiply and multiply by zero
    issue(3'd2, 16'hFFFF, 16'hFFFF, c_ow'(32'hFFFE0001), 1'b0, 1'b0, 1'b1, 1'b0, 1);
    measure_mul("mul_max");
    drain("mul_max_drain");
    issue(3'd2, 16'h0000, 16'h1234, '0, 1'b0, 1'b0, 1'b0, 1'b1, 1);
    measure_mul("mul_zero");
    drain("mul_zero_drain");

    // enables during MULT are ignored
    repeat (2) @(posedge clk);
    #1;
    d0 = n_done;
    issue(3'd2, 16'd3, 16'd5, c_ow'(15), 1'b0, 1'b0, 1'b0, 1'b1, 1);
    repeat (2) @(posedge clk);
    #1;
    enable = 1'b1;
    select = 3'd0;
    a      = 16'd1;
    b      = 16'd1;
    repeat (6) @(posedge clk);
    #1 enable = 1'b0;
    drain("mul_ignore_drain");
    repeat (4) @(negedge clk);
    check("mul_ignore_done_count", c_ow'(n_done - d0), c_ow'(1));

    // reset in the middle of a multiply
    repeat (2) @(posedge clk);
    #1;
    d0 = n_done;
    issue(3'd2, 16'hFFFF, 16'hFFFF, '0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    repeat (7) @(posedge clk);
    #1 arst = 1'b1;
    #1;
    check("arst_out", out, '0);
    check("arst_ctl", c_ow'({carry_out, a_greater, a_equal, a_less, busy, done}), '0);
    @(posedge clk);
    #1 arst = 1'b0;
    issue(3'd0, 16'd5, 16'd6, c_ow'(11), 1'b0, 1'b0, 1'b0, 1'b1, 1);
    drain("post_reset_add_drain");
    repeat (20) @(negedge clk);
    check("arst_no_stale_done", c_ow'(n_done - d0), c_ow'(1));

    // bitwise/compare/pass sweep
    issue(3'd3, 16'hF0F0, 16'hFF00, c_ow'(16'hF000), 1'b0, 1'b0, 1'b0, 1'b1, 1);
    issue(3'd4, 16'hF0F0, 16'hFF00, c_ow'(16'hFFF0), 1'b0, 1'b0, 1'b0, 1'b1, 1);
    issue(3'd5, 16'hF0F0, 16'hFF00, c_ow'(16'h0FF0), 1'b0, 1'b0, 1'b0, 1'b1, 1);
    issue(3'd6, 16'hF0F0, 16'hFF00, '0, 1'b0, 1'b0, 1'b0, 1'b1, 1);
    issue(3'd7, 16'hF0F0, 16'hFF00, c_ow'(16'hF0F0), 1'b0, 1'b0, 1'b0, 1'b1, 1);
    drain("sweep_drain");

    // outputs hold in IDLE
    repeat (3) @(negedge clk);
    check("idle_hold_out", out, c_ow'(16'hF0F0));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/alu_seq_core.md
# alu_seq_core

Sequential ALU responder driven by the `alu_if` stimulus bundle. It accepts one operation per `enable` pulse, computes it, and presents `out`, `carry_out` and the comparison flags with a one-cycle `done` strobe. Add, subtract, logic and compare complete in one cycle. Multiply uses an iterative shift-add engine, and `busy` is high while that engine runs. The block is the DUT side of the ALU verification environment and is instantiated directly against that interface.

## Interface
- `WIDTH`, 4: bits per ALU slice.
- `N_ALU`, 4: number of slices. Operand width is `W = WIDTH*N_ALU` (16 by default).
- `clk`  in  1  rising-edge clock.
- `arst`  in  1  asynchronous, active-high reset.
- `enable`  in  1  start strobe. It is sampled only when `busy` = 0.
- `select`  in  3  opcode.
- `a`, `b`  in  W  unsigned operands.
- `out`  out  8*W  result, zero-extended above its natural width.
- `carry_out`  out  1  carry (ADD) or borrow (SUB). 0 for all other ops.
- `a_greater`, `a_equal`, `a_less`  out  1 each  unsigned compare of the latched a and b. Exactly one is high after the first op.
- `busy`  out  1  multiply in progress.
- `done`  out  1  one-cycle strobe. `out`, `carry_out` and the flags are valid from this cycle until the next `done`.

## Operation
- Opcodes:
  - 0 ADD: `out = a+b` (W bits), `carry_out` = bit W of the sum.
  - 1 SUB: `out = |a-b|`, `carry_out = (b>a)`.
  - 2 MUL: `out = a*b`, 2W bits, exact.
  - 3 AND, 4 OR, 5 XOR: bitwise on W bits.
  - 6 CMP: `out = 0`, flags only.
  - 7 PASSA: `out = a`.
- Accept: `enable`=1 at a rising edge while state is IDLE or DONE. At that edge `a`, `b` and `select` are latched. Inputs are don't-care at all other edges.
- FSM states are IDLE, MULT and DONE.
  - IDLE → DONE on accept of a non-MUL op. The results are registered at the accepting edge.
  - IDLE/DONE → MULT on accept of MUL. The iteration counter clears and `busy` is set.
  - MULT → MULT while count < W−1. Each iteration adds the shifted multiplicand when the current multiplier LSB is 1.
  - MULT → DONE at iteration W. `out` is written at that edge.
  - DONE → IDLE when `enable`=0. DONE → DONE or MULT on a new accept, so back-to-back non-MUL ops are allowed.
- `done` = (state == DONE).
- `enable` while in MULT is ignored. It is neither queued nor does it alter the latched operands.
- Compare flags are updated on every accepted op, including MUL, at the accept edge.
- Outputs hold their last value in IDLE. `out` does not change during MULT; only the internal accumulator does.
- Reset while `arst`=1, asynchronous:
  - state goes to IDLE and the counter and accumulator clear.
  - `out`, `carry_out`, `busy` and `done` are 0.
  - all three flags are 0.
  - A reset during MULT discards the operation, and no `done` follows.
- Boundary behaviour:
  - ADD `0xFFFF+0x0001` wraps to 0 with carry 1.
  - SUB with a = b gives 0 with borrow 0.
  - MUL by 0 still takes the full W iterations.

## Timing
- Non-MUL: accept at edge E0, then `done`=1 and results valid in the cycle after E0. Latency is 1 cycle, throughput is 1 op/cycle.
- MUL: accept at E0, then `busy`=1 after E0 through E_W, then `done`=1 after E_W. Latency is W cycles, which is 16 by default.
- At E_W, `busy` falls in the same edge that `done` rises.
- Release of `arst` is synchronized by the integration layer. The first accept is legal at the first rising edge after deassertion.
- All outputs come directly from registers, with no combinational path from inputs to outputs.

## Structure
- `alu_pkg` holds:
  - `alu_op_e`, a 3-bit enum for the opcodes above.
  - `alu_state_e` with IDLE, MULT and DONE.
  - Default WIDTH/N_ALU constants.
- One sub-module, `alu_seq_mult`: the shift-add multiplier.
  - Inputs: start, a, b.
  - Outputs: product (2W bits) and last, a one-cycle strobe at iteration W.
  - It contains the counter and the accumulator.
- The top level holds the FSM, the single-cycle datapath and the output registers.

## Test plan
- ADD `a=0xFFFF, b=0x0001`, enable for 1 cycle → `out=0`, `carry_out=1`, `a_greater=1`, `done` in the next cycle only.
- SUB `a=3, b=10` → `out=7`, `carry_out=1`, `a_less=1`. Then SUB `a=10, b=10` back-to-back → `out=0`, `carry_out=0`, `a_equal=1`, `done` held 2 consecutive cycles.
- MUL `a=0xFFFF, b=0xFFFF` → `busy` high for 16 cycles, then `out=0xFFFE0001` with `done` 16 cycles after accept. MUL `a=0, b=0x1234` → `out=0` with the same latency.
- Enable pulses with `select=0, a=1, b=1` during MUL → ignored. The MUL result is unchanged and only one `done` is seen.
- `arst` pulse at iteration 8 of MUL → all outputs 0 immediately, and no `done`. A new ADD `5+6` right after release → `out=11`.
- Sweep ops 3–7 with `a=0xF0F0, b=0xFF00`:
  - AND → `0xF000`
  - OR → `0xFFF0`
  - XOR → `0x0FF0`
  - CMP → `out=0`, `a_less=1`
  - PASSA → `0xF0F0`
